// File: rtl/inst_fetch_queue.sv
// Fetch stage: PC register, in-order word requests to imem, response FIFO toward decode.
// Optional ILLEGAL_OPCODE_CHECK_EN adds the inst_illegal output.
module inst_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_code,
    output logic [31:0] inst_pc
`ifdef ILLEGAL_OPCODE_CHECK_EN
    ,
    output logic        inst_illegal
`endif
);

    localparam int unsigned CW = $clog2(QDEPTH + 1);
    localparam int unsigned AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } state_t;

    state_t        state, state_nxt;
    logic [31:0]   pc;
    logic [CW-1:0] count, outstanding, discard, discard_nxt;
    logic [CW:0]   inflight;

    logic [31:0]   qcode [QDEPTH];
    logic [31:0]   qpc   [QDEPTH];
    logic [31:0]   tag   [QDEPTH];
    logic [AW-1:0] qwr, qrd, twr, trd;

    logic          push, pop;
    logic          unused_rpc_bits;

    assign unused_rpc_bits = ^redirect_pc[1:0];

    assign inflight   = {1'b0, count} + {1'b0, outstanding};
    assign imem_req   = (state == FETCH) && (inflight < (CW+1)'(QDEPTH)) && !redirect_valid;
    assign imem_addr  = pc;

    assign inst_valid = (count != '0);
    assign inst_code  = inst_valid ? qcode[qrd] : '0;
    assign inst_pc    = inst_valid ? qpc[qrd]   : '0;

    // discard is nonzero only while draining, so it alone gates pushes
    assign push = imem_valid && (discard == '0) && !redirect_valid;
    assign pop  = inst_valid && inst_ready && !redirect_valid;

`ifdef ILLEGAL_OPCODE_CHECK_EN
    assign inst_illegal = inst_valid && (inst_code[1:0] != 2'b11);
`endif

    always_comb begin
        state_nxt   = state;
        discard_nxt = discard;
        unique case (state)
            IDLE:  state_nxt = FETCH;
            FETCH: state_nxt = FETCH;
            DRAIN: begin
                if (imem_valid)
                    discard_nxt = discard - 1'b1;
                if (discard_nxt == '0)
                    state_nxt = FETCH;
            end
            default: state_nxt = IDLE;
        endcase
        // a response arriving with the redirect is itself dropped
        if (redirect_valid) begin
            discard_nxt = outstanding - CW'(imem_valid);
            state_nxt   = (discard_nxt != '0) ? DRAIN : FETCH;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
            qwr         <= '0;
            qrd         <= '0;
            twr         <= '0;
            trd         <= '0;
        end else begin
            state       <= state_nxt;
            discard     <= discard_nxt;
            outstanding <= outstanding + CW'(imem_req) - CW'(imem_valid);
            if (imem_req) begin
                twr <= twr + 1'b1;
                pc  <= pc + 32'd4;
            end
            // tag FIFO keeps running through redirects so dropped responses stay aligned
            if (imem_valid)
                trd <= trd + 1'b1;
            if (redirect_valid) begin
                pc    <= {redirect_pc[31:2], 2'b00};
                count <= '0;
                qwr   <= '0;
                qrd   <= '0;
            end else begin
                if (push)
                    qwr <= qwr + 1'b1;
                if (pop)
                    qrd <= qrd + 1'b1;
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (imem_req)
            tag[twr] <= pc;
        if (push) begin
            qcode[qwr] <= imem_rdata;
            qpc[qwr]   <= tag[trd];
        end
    end

`ifndef SYNTHESIS
    no_push_when_full: assert property (@(posedge clk) disable iff (rst)
        !(push && (count == CW'(QDEPTH))));
`endif

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: directed scenarios plus random traffic checked against
// a queue-based model of the fetch stage and an in-order memory with variable latency.
module tb_inst_fetch_queue;

    localparam logic [31:0] RPC = 32'h0000_0100;
    localparam int unsigned QD  = 2;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_code;
    logic [31:0] inst_pc;
`ifdef ILLEGAL_OPCODE_CHECK_EN
    logic        inst_illegal;
`endif

    inst_fetch_queue #(
        .RESET_PC (RPC),
        .QDEPTH   (QD)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_valid     (imem_valid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_code      (inst_code),
        .inst_pc        (inst_pc)
`ifdef ILLEGAL_OPCODE_CHECK_EN
        ,
        .inst_illegal   (inst_illegal)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          due;
        bit          stale;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] code;
    } ent_t;

    req_t        infl[$];
    ent_t        fifo[$];
    logic [31:0] mpc;
    bit          started;
    int          cyc;
    int unsigned lat;
    bit          fixed_en;
    logic [31:0] fixed_val;
    int          passed;
    int          total;

    bit          c_redir, c_rdy, c_resp, c_ereq, c_evld;
    logic [31:0] c_rpc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic bit stale_any();
        foreach (infl[i])
            if (infl[i].stale) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        mpc     = RPC;
        started = 1'b0;
        fifo.delete();
        infl.delete();
    endtask

    // Drive one cycle's inputs (at negedge) and compare outputs with the model.
    task automatic cyc_begin(input bit redir, input logic [31:0] rpc, input bit rdy);
        ent_t h;
        c_redir = redir;
        c_rpc   = rpc;
        c_rdy   = rdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        inst_ready     = rdy;
        c_resp = (infl.size() > 0) && (infl[0].due == cyc);
        imem_valid = c_resp;
        imem_rdata = c_resp ? infl[0].data : $urandom;
        #1;
        c_ereq = started && !stale_any() && ((fifo.size() + infl.size()) < QD) && !redir;
        c_evld = (fifo.size() != 0);
        h.pc   = 32'h0;
        h.code = 32'h0;
        if (c_evld) h = fifo[0];
        check("imem_req",   32'(imem_req),   32'(c_ereq));
        check("imem_addr",  imem_addr,       mpc);
        check("inst_valid", 32'(inst_valid), 32'(c_evld));
        check("inst_code",  inst_code,       h.code);
        check("inst_pc",    inst_pc,         h.pc);
`ifdef ILLEGAL_OPCODE_CHECK_EN
        check("inst_illegal", 32'(inst_illegal), 32'(c_evld && (h.code[1:0] != 2'b11)));
`endif
    endtask

    // Advance the model through the clock edge, then move to the next negedge.
    task automatic cyc_end();
        req_t f;
        ent_t e;
        bit   do_push;
        do_push = 1'b0;
        if (c_resp) begin
            f = infl.pop_front();
            if (!c_redir && !f.stale) begin
                e.pc    = f.addr;
                e.code  = f.data;
                do_push = 1'b1;
            end
        end
        if (!c_redir && c_evld && c_rdy) void'(fifo.pop_front());
        if (do_push) fifo.push_back(e);
        if (c_ereq) begin
            f.addr  = mpc;
            f.data  = fixed_en ? fixed_val : $urandom;
            f.due   = cyc + int'(lat);
            if (infl.size() > 0 && f.due <= infl[infl.size()-1].due)
                f.due = infl[infl.size()-1].due + 1;
            f.stale = 1'b0;
            infl.push_back(f);
            mpc = mpc + 32'd4;
        end
        if (c_redir) begin
            fifo.delete();
            foreach (infl[i]) infl[i].stale = 1'b1;
            mpc = {c_rpc[31:2], 2'b00};
        end
        started = 1'b1;
        @(posedge clk);
        cyc = cyc + 1;
        @(negedge clk);
    endtask

    task automatic step(input bit redir, input logic [31:0] rpc, input bit rdy);
        cyc_begin(redir, rpc, rdy);
        cyc_end();
    endtask

    // Asserted away from the clock edge: outputs must fall before any edge arrives.
    task automatic do_reset();
        rst            = 1'b1;
        imem_valid     = 1'b0;
        imem_rdata     = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        inst_ready     = 1'b0;
        #1;
        check("rst_imem_req",   32'(imem_req),   32'h0);
        check("rst_imem_addr",  imem_addr,       RPC);
        check("rst_inst_valid", 32'(inst_valid), 32'h0);
        check("rst_inst_code",  inst_code,       32'h0);
        check("rst_inst_pc",    inst_pc,         32'h0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        cyc    = 0;
        lat    = 1;
        fixed_en  = 1'b0;
        fixed_val = 32'h0;
        rst = 1'b0;
        model_reset();
        #2;

        // T1/T2: startup timing and first instruction delivered
        do_reset();
        fixed_en  = 1'b1;
        fixed_val = 32'h0050_0093;
        lat = 1;
        cyc_begin(1'b0, 32'h0, 1'b1);
        check("t1_c1_req", 32'(imem_req), 32'h0);
        cyc_end();
        cyc_begin(1'b0, 32'h0, 1'b1);
        check("t1_c2_req",  32'(imem_req), 32'h1);
        check("t1_c2_addr", imem_addr,     32'h0000_0100);
        cyc_end();
        cyc_begin(1'b0, 32'h0, 1'b1);
        check("t1_c3_addr", imem_addr, 32'h0000_0104);
        cyc_end();
        cyc_begin(1'b0, 32'h0, 1'b1);
        check("t2_valid", 32'(inst_valid), 32'h1);
        check("t2_pc",    inst_pc,         32'h0000_0100);
        check("t2_code",  inst_code,       32'h0050_0093);
        cyc_end();
        fixed_en = 1'b0;
        repeat (4) step(1'b0, 32'h0, 1'b1);

        // T3: back-pressure fills the queue, then drains in order
        do_reset();
        lat = 1;
        repeat (4) step(1'b0, 32'h0, 1'b0);
        cyc_begin(1'b0, 32'h0, 1'b0);
        check("t3_full_req", 32'(imem_req), 32'h0);
        check("t3_head_pc",  inst_pc,       32'h0000_0100);
        cyc_end();
        step(1'b0, 32'h0, 1'b1);
        cyc_begin(1'b0, 32'h0, 1'b1);
        check("t3_second_pc", inst_pc,        32'h0000_0104);
        check("t3_next_req",  32'(imem_req),  32'h1);
        check("t3_next_addr", imem_addr,      32'h0000_0108);
        cyc_end();
        repeat (3) step(1'b0, 32'h0, 1'b1);

        // T4: redirect with two requests in flight
        do_reset();
        lat = 3;
        repeat (3) step(1'b0, 32'h0, 1'b1);
        step(1'b1, 32'h0000_0203, 1'b1);
        cyc_begin(1'b0, 32'h0, 1'b1);
        check("t4_drop1_req", 32'(imem_req), 32'h0);
        cyc_end();
        cyc_begin(1'b0, 32'h0, 1'b1);
        check("t4_drop2_valid", 32'(inst_valid), 32'h0);
        cyc_end();
        cyc_begin(1'b0, 32'h0, 1'b1);
        check("t4_new_req",  32'(imem_req), 32'h1);
        check("t4_new_addr", imem_addr,     32'h0000_0200);
        cyc_end();

        // Random traffic: latency, back-pressure and redirects
        for (int i = 0; i < 600; i++) begin
            lat = $urandom_range(4, 1);
            step(($urandom_range(11, 0) == 0), $urandom, ($urandom_range(3, 0) != 0));
        end

        // T5: asynchronous reset while the queue is full
        lat = 1;
        repeat (6) step(1'b0, 32'h0, 1'b0);
        cyc_begin(1'b0, 32'h0, 1'b0);
        check("t5_full_before_rst", 32'(inst_valid), 32'h1);
        do_reset();
        step(1'b0, 32'h0, 1'b1);
        cyc_begin(1'b0, 32'h0, 1'b1);
        check("t5_refetch_addr", imem_addr, RPC);
        cyc_end();

        for (int i = 0; i < 300; i++) begin
            lat = $urandom_range(4, 1);
            step(($urandom_range(15, 0) == 0), $urandom, ($urandom_range(3, 0) != 0));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
